// File: rtl/scan_seq_ctrl.sv
// Scan-test sequencer: loads one parallel pattern per handshake into the scan chain,
// runs the capture window, and unloads/checks the previous capture during the next shift.
module scan_seq_ctrl #(
    parameter int CHAIN_LEN  = 16,
    parameter int CAP_CYCLES = 1,
    parameter int CNT_W      = 6
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic [CHAIN_LEN-1:0] pat_expect,
    input  logic [CHAIN_LEN-1:0] pat_mask,
    input  logic                 pat_last,
    input  logic                 abort,
    output logic                 scan_enable,
    output logic                 scan_data_in,
    input  logic                 scan_data_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 rsp_fail,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, UNLOAD} state_t;

    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LOAD   = CNT_W'(CAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 drain, drain_next;
    logic [CHAIN_LEN-1:0] shift_reg, rsp_reg, rsp_word;
    logic [CHAIN_LEN-1:0] exp_reg, mask_reg, cmp_exp, cmp_mask;
    logic                 last_reg, cap_pending;
    logic                 accept, shift_en, sample, word_done, cap_done;

    assign pat_ready    = (state == IDLE) && !rsp_valid && !abort;
    assign accept       = pat_valid && pat_ready;
    assign scan_data_in = shift_reg[CHAIN_LEN-1];
    // While draining, the full word already sits in rsp_reg and SO is no longer sampled.
    assign rsp_word     = drain ? rsp_reg : {rsp_reg[CHAIN_LEN-2:0], scan_data_out};

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            cnt   <= '0;
            drain <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            drain <= drain_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        drain_next = drain;
        shift_en   = 1'b0;
        sample     = 1'b0;
        word_done  = 1'b0;
        cap_done   = 1'b0;
        if (abort) begin
            state_next = IDLE;
            cnt_next   = '0;
            drain_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_next = SHIFT;
                        cnt_next   = SHIFT_LOAD;
                    end
                end
                SHIFT: begin
                    shift_en = 1'b1;
                    sample   = 1'b1;
                    if (cnt == '0) begin
                        word_done  = 1'b1;
                        state_next = CAPTURE;
                        cnt_next   = CAP_LOAD;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                CAPTURE: begin
                    if (cnt == '0) begin
                        cap_done   = 1'b1;
                        state_next = last_reg ? UNLOAD : IDLE;
                        cnt_next   = last_reg ? SHIFT_LOAD : '0;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                UNLOAD: begin
                    // If the host still holds the shift-phase response, park here shifting
                    // zeros (chain content is already in rsp_reg) until it is taken.
                    shift_en = 1'b1;
                    sample   = !drain;
                    if (cnt != '0) begin
                        cnt_next = cnt - CNT_ONE;
                    end else if (rsp_valid && !rsp_ready) begin
                        drain_next = 1'b1;
                    end else begin
                        word_done  = 1'b1;
                        drain_next = 1'b0;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            shift_reg   <= '0;
            cap_pending <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_fail    <= 1'b0;
            scan_enable <= 1'b0;
            busy        <= 1'b0;
        end else begin
            scan_enable <= (state_next == SHIFT) || (state_next == UNLOAD);
            busy        <= (state_next != IDLE);
            if (abort) begin
                shift_reg   <= '0;
                cap_pending <= 1'b0;
                rsp_valid   <= 1'b0;
                rsp_fail    <= 1'b0;
            end else begin
                if (accept)
                    shift_reg <= pat_data;
                else if (shift_en)
                    shift_reg <= shift_reg << 1;
                if (rsp_valid && rsp_ready)
                    rsp_valid <= 1'b0;
                if (word_done && cap_pending) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= rsp_word;
                    rsp_fail  <= |((rsp_word ^ cmp_exp) & cmp_mask);
                end
                if (cap_done)
                    cap_pending <= 1'b1;
                else if (word_done && (state == UNLOAD))
                    cap_pending <= 1'b0;
            end
        end
    end

    // cmp_* hold the expect/mask of whichever pattern's capture is currently being unloaded.
    always_ff @(posedge CK) begin
        if (sample)
            rsp_reg <= {rsp_reg[CHAIN_LEN-2:0], scan_data_out};
        if (accept) begin
            exp_reg  <= pat_expect;
            mask_reg <= pat_mask;
            last_reg <= pat_last;
            cmp_exp  <= exp_reg;
            cmp_mask <= mask_reg;
        end else if (cap_done && last_reg) begin
            cmp_exp  <= exp_reg;
            cmp_mask <= mask_reg;
        end
    end

endmodule
